// File: rtl/out_uart_if.sv
// Core-to-output-stage word strobe bundle.
// The core drives it through the master modport, and out_uart_tx receives it through the slave modport.
interface out_uart_if;
    logic        out_en;
    logic [15:0] out_dat;
    logic        is_halt;

    modport master (output out_en, output out_dat, output is_halt);
    modport slave  (input  out_en, input  out_dat, input  is_halt);
endinterface

// File: rtl/out_uart_tx.sv
// Buffers core output words in a FIFO and sends each word as two 8N1 UART bytes, high byte first.
// It also flags dropped words and reports when the output has drained after a halt.
module out_uart_tx #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                     clk,
    input  logic                     reset,
    out_uart_if.slave                core,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [CW-1:0] TIMER_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;

    logic [1:0]    state_reg;
    logic [CW-1:0] timer_reg;
    logic [2:0]    bit_reg;
    logic          byte_hi_reg;
    logic [15:0]   shift_reg;
    logic [7:0]    cur_byte;

    logic pop;
    logic push;
    logic bit_done;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop      = (state_reg == ST_IDLE) && (count_reg != '0);
    assign push     = core.out_en && ((count_reg != COUNT_FULL) || pop);
    assign bit_done = (timer_reg == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= core.out_dat;
        end
    end

    // Read-before-write: a pop on a full FIFO sees the old head even when a push targets the same slot.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (core.out_en && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_reg     <= '0;
            byte_hi_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    timer_reg <= '0;
                    if (pop) begin
                        byte_hi_reg <= 1'b1;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        bit_reg   <= '0;
                        state_reg <= ST_DATA;
                    end else begin
                        timer_reg <= timer_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                        end
                    end else begin
                        timer_reg <= timer_reg + CW'(1);
                    end
                end
                default: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        if (byte_hi_reg) begin
                            byte_hi_reg <= 1'b0;
                            state_reg   <= ST_START;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        timer_reg <= timer_reg + CW'(1);
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_sel
        assign cur_byte[gi] = byte_hi_reg ? shift_reg[8 + gi] : shift_reg[gi];
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = cur_byte[bit_reg];
            default:  tx = 1'b1;
        endcase
    end

    assign busy       = (count_reg != '0) || (state_reg != ST_IDLE);
    assign overflow   = overflow_reg;
    assign fifo_count = count_reg;
    assign drained    = core.is_halt && (count_reg == '0) && (state_reg == ST_IDLE);
endmodule

// File: tb/tb_out_uart_tx.sv
// Randomised scoreboard bench for out_uart_tx.
// A word-level model predicts the accepted words and their byte start times, and a UART receiver checks the tx line against that prediction.
module tb_out_uart_tx;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int WORD_CYCLES = 20 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx, busy, overflow, drained;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    out_uart_if bus();

    out_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .core       (bus.slave),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .drained    (drained)
    );

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    int  idle_from = 0;
    bit  ovf_m = 0;
    bit  halt_v = 0;
    bit  halt_drv = 0;
    bit  chk_on = 0;
    int  cyc = 0;
    int  epoch = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, then advance the model.
    task automatic step(input bit en, input logic [15:0] dat, input bit rst);
        logic [15:0] w;
        @(negedge clk);
        if (chk_on) begin
            chk("fifo_count", 32'(fifo_count), mq.size());
            chk("overflow", 32'(overflow), 32'(ovf_m));
            chk("busy", 32'(busy), 32'(mq.size() != 0 || cyc < idle_from));
            chk("drained", 32'(drained), 32'(halt_drv && mq.size() == 0 && cyc >= idle_from));
            if (cyc >= idle_from) chk("tx_idle", 32'(tx), 32'd1);
        end
        bus.out_en  = en;
        bus.out_dat = dat;
        bus.is_halt = halt_v;
        halt_drv    = halt_v;
        reset       = rst;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            ovf_m     = 0;
            idle_from = cyc + 1;
            epoch++;
            chk_on    = 1;
        end else begin
            if (cyc >= idle_from && mq.size() > 0) begin
                w = mq.pop_front();
                exp_q.push_back('{b: w[15:8], start: cyc + 1});
                exp_q.push_back('{b: w[7:0],  start: cyc + 1 + 10 * CPB});
                idle_from = cyc + WORD_CYCLES;
            end
            if (en) begin
                if (mq.size() < DEPTH) mq.push_back(dat);
                else ovf_m = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 1'b0);
    endtask

    // UART receiver: samples mid-bit and matches each byte against the expected queue.
    initial begin
        exp_t       e;
        int         s;
        int         ep;
        logic [7:0] rx;
        logic       start_b;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (chk_on && reset === 1'b0 && tx === 1'b0) begin
                s  = cyc;
                ep = epoch;
                repeat (CPB / 2) @(negedge clk);
                start_b = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_b = tx;
                if (ep == epoch) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame cycle %0d: got byte %02h expected no frame", s, rx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_start_cycle", s, e.start);
                        chk("rx_byte", 32'(rx), 32'(e.b));
                        chk("rx_start_bit", 32'(start_b), 32'd0);
                        chk("rx_stop_bit", 32'(stop_b), 32'd1);
                        $display("rx byte %02h start cycle %0d", rx, s);
                    end
                end
                repeat (CPB / 2 - 1) @(negedge clk);
            end
        end
    end

    initial begin
        int guard;
        int burst;
        bus.out_en  = 1'b0;
        bus.out_dat = 16'h0;
        bus.is_halt = 1'b0;

        // Reset held three cycles, then the outputs are checked against the cleared model.
        repeat (3) step(1'b0, 16'h0, 1'b1);
        idle(2);

        // Single word.
        step(1'b1, 16'h1234, 1'b0);
        idle(WORD_CYCLES + 10);

        // Six-word burst: the sixth word is dropped.
        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0);
        idle(5 * WORD_CYCLES + 10);
        step(1'b0, 16'h0, 1'b1);

        // Full FIFO with a push landing exactly in the IDLE pop cycle.
        step(1'b1, 16'hAAAA, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0);
        guard = 0;
        while (cyc + 1 < idle_from && guard < 200) begin
            step(1'b0, 16'h0, 1'b0);
            guard++;
        end
        step(1'b1, 16'hC0DE, 1'b0);
        idle(6 * WORD_CYCLES + 10);

        // Reset during data bit 3 of the high byte.
        step(1'b1, 16'hA5A5, 1'b0);
        idle(18);
        step(1'b0, 16'h0, 1'b1);
        idle(60);

        // Drain after halt.
        halt_v = 1;
        step(1'b1, 16'h00FF, 1'b0);
        idle(WORD_CYCLES + 10);
        halt_v = 0;
        idle(2);

        // Random traffic with occasional bursts, halts and resets.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(2, 6);
            if ($urandom_range(0, 99) == 0) halt_v = ~halt_v;
            if ($urandom_range(0, 1499) == 0) begin
                step(1'b0, 16'h0, 1'b1);
                idle(45);
            end else if (burst > 0) begin
                step(1'b1, 16'($urandom), 1'b0);
                burst--;
            end else begin
                step($urandom_range(0, 59) == 0, 16'($urandom), 1'b0);
            end
        end

        guard = 0;
        while ((mq.size() != 0 || cyc < idle_from || exp_q.size() != 0) && guard < 1000) begin
            step(1'b0, 16'h0, 1'b0);
            guard++;
        end
        idle(5);
        chk("frames_outstanding", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
